nibble_sequencer: RTL and testbench
===================================

# nibble_sequencer

Parametrised nibble-index sequencer for the nibble-serial datapath, succeeding the single-pass nibble counter. It runs one or more passes over an operand of programmable nibble length, counting up or down. It adds start/done handshaking, stall (advance) control, abort, and per-nibble first/last flags, so ALU and shifter control can run multi-pass operations (multiply, compare-then-subtract) without external bookkeeping.

## Interface
- WIDTH, 3, width of nibble index and length fields
- PASS_W, 2, width of pass count and pass index

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request new sequence; accepted only in IDLE
- len  in  WIDTH  index of last nibble (nibble count − 1); sampled on accepted start
- reverse  in  1  0: count 0→len; 1: count len→0; sampled on accepted start
- passes  in  PASS_W  extra passes (0 = one pass); sampled on accepted start
- advance  in  1  consume current nibble and step; ignored outside RUN
- abort  in  1  synchronous return to IDLE
- idx  out  WIDTH  current nibble index
- pass_idx  out  PASS_W  current pass, 0-based
- valid  out  1  high in RUN; idx/first/last meaningful
- first  out  1  idx is first nibble of current pass (valid-qualified)
- last  out  1  idx is last nibble of current pass (valid-qualified)
- busy  out  1  high in RUN
- done  out  1  one-cycle registered pulse after final nibble consumed

## Operation
- States: IDLE, RUN. Reset → IDLE.
- Latched config: len_q, reverse_q, passes_q, loaded on accepted start.
- Start value s = reverse ? len : 0; end value e = reverse ? 0 : len (computed from latched values in RUN).
- IDLE: start & ~abort → RUN, idx ← s (from live inputs), pass_idx ← 0.
- RUN, abort=1 → IDLE, idx ← 0, pass_idx ← 0, no done pulse. Abort beats advance.
- RUN, advance=0 → hold all state.
- RUN, advance=1:
  - idx ≠ e → idx ← reverse_q ? idx−1 : idx+1.
  - idx = e, pass_idx ≠ passes_q → pass_idx+1, idx ← s.
  - idx = e, pass_idx = passes_q → IDLE, done ← 1 next cycle, idx ← 0, pass_idx ← 0.
- first = valid & (idx = s); last = valid & (idx = e); both 0 outside RUN.
- len = 0: first and last both 1 on every nibble; each advance ends a pass.
- len = 2^WIDTH−1: full range, no wrap. Terminal compare stops before overflow.
- start in RUN ignored; live config changes in RUN ignored.
- start and abort together in IDLE: abort wins, stay IDLE.

## Timing
- Reset values: idx=0, pass_idx=0, valid=0, busy=0, first=0, last=0, done=0; config regs 0.
- Start accepted at edge N → valid=1 with idx=s from cycle N+1.
- One nibble per advance-high cycle. With advance held high: (passes+1)·(len+1) cycles in RUN, then done=1 for exactly one cycle. valid=0 in that cycle.
- start asserted in the done cycle is accepted (state is IDLE); RUN resumes the following cycle, so back-to-back sequences have a one-cycle gap.
- rst_n low at any time (mid-pass included) clears all state immediately. No done pulse. Reset release is synchronised externally.
- Outputs idx, pass_idx, valid, busy, done are registered. first/last are combinational from registered state only, with no input-to-output path.

## Test plan
- Reset mid-RUN (len=5, idx=3) → all outputs 0 immediately, IDLE after release, no done.
- start, len=2, reverse=0, passes=0, advance=1 → idx 0,1,2, first at 0, last at 2; done one cycle after idx=2 consumed; 3 valid cycles.
- start, len=2, reverse=1, passes=2 → idx 2,1,0 repeated three times, pass_idx 0,1,2, first at 2, last at 0; 9 valid cycles then done.
- len=7, reverse=0, advance toggling 1,0 → each idx held two cycles, 0..7 with no wrap to 0 before done; len=0, passes=3 → 4 valid cycles, first=last=1 each.
- abort at pass_idx=1, idx=4 (len=7), asserted together with advance → IDLE next cycle, no done; start in same cycle as abort in IDLE → ignored.
- start held high through RUN and the done cycle with new len=1 → first sequence unaffected; new sequence idx 0,1 begins the cycle after done.

Source files
------------

// File: rtl/nibble_sequencer.sv
// rtl/nibble_sequencer.sv - multi-pass nibble index sequencer with start/done, stall and abort
module nibble_sequencer #(
   parameter int WIDTH  = 3,
   parameter int PASS_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WIDTH-1:0]  len,
   input  logic              reverse,
   input  logic [PASS_W-1:0] passes,
   input  logic              advance,
   input  logic              abort,
   output logic [WIDTH-1:0]  idx,
   output logic [PASS_W-1:0] pass_idx,
   output logic              valid,
   output logic              first,
   output logic              last,
   output logic              busy,
   output logic              done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [WIDTH-1:0]   len_q;
   logic               reverse_q;
   logic [PASS_W-1:0]  passes_q;
   logic [WIDTH-1:0]   s_val;
   logic [WIDTH-1:0]   e_val;

   // Start/end of a pass come from the latched config so live input changes cannot disturb a run.
   assign s_val = reverse_q ? len_q : '0;
   assign e_val = reverse_q ? '0 : len_q;

   assign first = valid & (idx == s_val);
   assign last  = valid & (idx == e_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         len_q     <= '0;
         reverse_q <= 1'b0;
         passes_q  <= '0;
         idx       <= '0;
         pass_idx  <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  state     <= RUN;
                  len_q     <= len;
                  reverse_q <= reverse;
                  passes_q  <= passes;
                  idx       <= reverse ? len : '0;
                  pass_idx  <= '0;
                  valid     <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  state    <= IDLE;
                  idx      <= '0;
                  pass_idx <= '0;
                  valid    <= 1'b0;
                  busy     <= 1'b0;
               end else if (advance) begin
                  // Terminal compare happens before stepping, so len = all-ones never wraps.
                  if (idx != e_val) begin
                     idx <= reverse_q ? idx - WIDTH'(1) : idx + WIDTH'(1);
                  end else if (pass_idx != passes_q) begin
                     pass_idx <= pass_idx + PASS_W'(1);
                     idx      <= s_val;
                  end else begin
                     state    <= IDLE;
                     idx      <= '0;
                     pass_idx <= '0;
                     valid    <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_sequencer.sv
// tb/tb_nibble_sequencer.sv - scoreboard bench for nibble_sequencer
module tb_nibble_sequencer;

   localparam int WIDTH  = 3;
   localparam int PASS_W = 2;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [WIDTH-1:0]  len;
   logic              reverse;
   logic [PASS_W-1:0] passes;
   logic              advance;
   logic              abort;
   logic [WIDTH-1:0]  idx;
   logic [PASS_W-1:0] pass_idx;
   logic              valid;
   logic              first;
   logic              last;
   logic              busy;
   logic              done;

   typedef struct {
      logic [WIDTH-1:0]  idx;
      logic [PASS_W-1:0] pass;
      logic              first;
      logic              last;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;

   nibble_sequencer #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .reverse(reverse),
      .passes(passes), .advance(advance), .abort(abort), .idx(idx),
      .pass_idx(pass_idx), .valid(valid), .first(first), .last(last),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_seq(input int l, input bit r, input int p);
      exp_t e;
      for (int pi = 0; pi <= p; pi++) begin
         for (int k = 0; k <= l; k++) begin
            e.idx   = WIDTH'(r ? l - k : k);
            e.pass  = PASS_W'(pi);
            e.first = (k == 0);
            e.last  = (k == l);
            exp_q.push_back(e);
         end
      end
   endtask

   // Runs from the start cycle to the done pulse, comparing each visible nibble to the queue head.
   task automatic drain(input bit toggle, input bit hold);
      int cyc;
      bit fin;
      logic [WIDTH+PASS_W+2:0] got, want;
      cyc = 0;
      fin = 0;
      while (!fin && cyc < 200) begin
         @(negedge clk);
         if (cyc == 0) begin
            vectors++;
            if (valid !== 1'b1) begin
               miscompares++;
               $display("FAIL start_latency: valid=%b expected 1", valid);
            end
         end
         if (!hold) start = 1'b0;
         if (valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL extra_nibble: idx=%0d pass=%0d with empty scoreboard", idx, pass_idx);
               advance = 1'b1;
            end else begin
               got  = {idx, pass_idx, first, last, busy};
               want = {exp_q[0].idx, exp_q[0].pass, exp_q[0].first, exp_q[0].last, 1'b1};
               if (got !== want) begin
                  miscompares++;
                  $display("FAIL nibble {idx,pass,first,last,busy}: got %h expected %h", got, want);
               end
               advance = toggle ? (cyc % 2 == 1) : 1'b1;
               if (advance) void'(exp_q.pop_front());
            end
         end else begin
            vectors++;
            if ({first, last, busy} !== 3'b000) begin
               miscompares++;
               $display("FAIL idle_flags {first,last,busy}: got %b expected 000", {first, last, busy});
            end
            if (done === 1'b1) begin
               fin = 1;
               vectors++;
               if (exp_q.size() != 0) begin
                  miscompares++;
                  $display("FAIL early_done: %0d nibbles left, expected 0", exp_q.size());
               end
            end else if (cyc > 0) begin
               miscompares++;
               $display("FAIL dropped_run: valid=0 done=%b expected done=1", done);
               fin = 1;
            end
         end
         cyc++;
      end
      if (!fin) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: no done after %0d cycles", cyc);
      end
      exp_q.delete();
   endtask

   task automatic check_quiet(input string name);
      vectors++;
      if ({valid, busy, done, first, last, idx, pass_idx} !== '0) begin
         miscompares++;
         $display("FAIL %s {valid,busy,done,first,last,idx,pass}: got %b expected 0", name,
                  {valid, busy, done, first, last, idx, pass_idx});
      end
   endtask

   task automatic run_seq(input int l, input bit r, input int p, input bit toggle);
      start   = 1'b1;
      len     = WIDTH'(l);
      reverse = r;
      passes  = PASS_W'(p);
      advance = 1'b1;
      push_seq(l, r, p);
      drain(toggle, 1'b0);
      @(negedge clk);
      check_quiet("done_one_cycle");
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; len = '0; reverse = 1'b0; passes = '0;
      advance = 1'b0; abort = 1'b0;
      #3;
      check_quiet("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1; len = 3'd5; advance = 1'b1;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      vectors++;
      if ({valid, idx} !== {1'b1, 3'd3}) begin
         miscompares++;
         $display("FAIL reset_pre {valid,idx}: got %b expected 1011", {valid, idx});
      end
      advance = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_quiet("reset_async");
      @(negedge clk);
      check_quiet("reset_held");
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_quiet("reset_after");
      end
   endtask

   task automatic test_forward;     run_seq(2, 1'b0, 0, 1'b0); endtask
   task automatic test_reverse;     run_seq(2, 1'b1, 2, 1'b0); endtask
   task automatic test_stall_full;  run_seq(7, 1'b0, 0, 1'b1); endtask
   task automatic test_len_zero;    run_seq(0, 1'b0, 3, 1'b0); endtask
   task automatic test_rev_full;    run_seq(7, 1'b1, 1, 1'b0); endtask

   task automatic test_abort;
      logic [WIDTH+PASS_W+2:0] got, want;
      start = 1'b1; len = 3'd7; reverse = 1'b0; passes = 2'd2; advance = 1'b1;
      push_seq(7, 1'b0, 2);
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         start = 1'b0;
         vectors++;
         got  = {idx, pass_idx, first, last, busy};
         want = {exp_q[0].idx, exp_q[0].pass, exp_q[0].first, exp_q[0].last, 1'b1};
         if (got !== want) begin
            miscompares++;
            $display("FAIL abort_run {idx,pass,first,last,busy}: got %h expected %h", got, want);
         end
         void'(exp_q.pop_front());
      end
      @(negedge clk);
      vectors++;
      if ({valid, pass_idx, idx} !== {1'b1, 2'd1, 3'd4}) begin
         miscompares++;
         $display("FAIL abort_point {valid,pass,idx}: got %b expected 101100", {valid, pass_idx, idx});
      end
      abort = 1'b1;
      advance = 1'b1;
      @(negedge clk);
      check_quiet("abort_idle");
      start = 1'b1;
      @(negedge clk);
      check_quiet("abort_beats_start");
      start = 1'b0;
      abort = 1'b0;
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         check_quiet("abort_no_done");
      end
   endtask

   task automatic test_back_to_back;
      start = 1'b1; len = 3'd2; reverse = 1'b0; passes = '0; advance = 1'b1;
      push_seq(2, 1'b0, 0);
      @(posedge clk);
      #1 len = 3'd1;
      exp_q.delete();
      push_seq(2, 1'b0, 0);
      drain(1'b0, 1'b1);
      push_seq(1, 1'b0, 0);
      drain(1'b0, 1'b0);
      @(negedge clk);
      check_quiet("b2b_done_one_cycle");
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_forward();
      test_reverse();
      test_stall_full();
      test_len_zero();
      test_rev_full();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
